// File: rtl/sys_mem_responder.sv
// rtl/sys_mem_responder.sv - word-addressed system memory responder with fixed-latency read pipeline
module sys_mem_responder #(
    parameter int          ADDR_W = 10,
    parameter int          RD_LAT = 1,
    parameter logic [15:0] BASE   = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Addr,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Valid,
    output logic        Err,
    output logic [15:0] RdCount,
    output logic [15:0] WrCount
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("sys_mem_responder: RD_LAT must be in 1..4");
        end
    endgenerate

    logic [15:0]       off;
    logic              in_range;
    logic [ADDR_W-1:0] idx;

    logic              req_read;
    logic              req_write;
    logic              req_bad;
    logic              mem_we;
    logic [15:0]       rd_word;

    logic [15:0]       mem_q [DEPTH];

    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [15:0]       pipe_data_q [RD_LAT];
    logic [15:0]       pipe_data_d [RD_LAT];
    logic [15:0]       data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [15:0]       rd_count_q, rd_count_d;
    logic [15:0]       wr_count_q, wr_count_d;

    // Bus address to array offset; wraps modulo 2^16 so BASE near the top still works.
    always_comb begin
        off      = Addr - BASE;
        in_range = (off >> ADDR_W) == 16'd0;
        idx      = off[ADDR_W-1:0];
    end

    // Classify the request; anything other than a clean 0/1 pair (conflict or unknown) is an error.
    always_comb begin
        req_read  = 1'b0;
        req_write = 1'b0;
        req_bad   = 1'b0;
        case ({RD, WR})
            2'b00:   begin end
            2'b10:   req_read  = 1'b1;
            2'b01:   req_write = 1'b1;
            2'b11:   req_bad   = 1'b1;
            default: req_bad   = 1'b1;
        endcase
        mem_we  = req_write & in_range;
        rd_word = in_range ? mem_q[idx] : 16'h0000;
    end

    // Array storage; deliberately not reset so contents survive Reset.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[idx] <= DataIn;
        end
    end

    // Next-state: shift the read pipeline, update sticky error and saturating counters.
    always_comb begin
        pipe_vld_d     = '0;
        pipe_data_d    = '{default: 16'h0000};
        pipe_vld_d[0]  = req_read;
        pipe_data_d[0] = rd_word;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
        valid_d    = pipe_vld_q[RD_LAT-1];
        data_out_d = valid_d ? pipe_data_q[RD_LAT-1] : data_out_q;
        err_d      = err_q | req_bad | ((req_read | req_write) & ~in_range);
        rd_count_d = (req_read && rd_count_q != 16'hFFFF) ? rd_count_q + 16'd1 : rd_count_q;
        wr_count_d = (mem_we && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
    end

    // State registers; async reset drops in-flight reads so they never surface.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pipe_vld_q  <= '0;
            pipe_data_q <= '{default: 16'h0000};
            data_out_q  <= 16'h0000;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            rd_count_q  <= 16'h0000;
            wr_count_q  <= 16'h0000;
        end else begin
            pipe_vld_q  <= pipe_vld_d;
            pipe_data_q <= pipe_data_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign DataOut = data_out_q;
    assign Valid   = valid_q;
    assign Err     = err_q;
    assign RdCount = rd_count_q;
    assign WrCount = wr_count_q;

endmodule

// File: tb/tb_sys_mem_responder.sv
// tb/tb_sys_mem_responder.sv - directed self-checking bench for sys_mem_responder
module tb_sys_mem_responder;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] din;

    logic [15:0] d2_dout, d3_dout;
    logic        d2_valid, d3_valid;
    logic        d2_err, d3_err;
    logic [15:0] d2_rdc, d3_rdc;
    logic [15:0] d2_wrc, d3_wrc;

    int checks = 0;
    int errors = 0;

    sys_mem_responder #(.ADDR_W(10), .RD_LAT(2), .BASE(16'h0000)) u_dut2 (
        .Clk(clk), .Reset(rst), .Addr(addr), .RD(rd), .WR(wr), .DataIn(din),
        .DataOut(d2_dout), .Valid(d2_valid), .Err(d2_err), .RdCount(d2_rdc), .WrCount(d2_wrc)
    );

    sys_mem_responder #(.ADDR_W(10), .RD_LAT(3), .BASE(16'h0000)) u_dut3 (
        .Clk(clk), .Reset(rst), .Addr(addr), .RD(rd), .WR(wr), .DataIn(din),
        .DataOut(d3_dout), .Valid(d3_valid), .Err(d3_err), .RdCount(d3_rdc), .WrCount(d3_wrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        rd = r; wr = w; addr = a; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rd = 1'b0; wr = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({d2_dout, d2_valid, d2_err, d2_rdc, d2_wrc} !== 50'd0) begin
            errors++;
            $display("FAIL reset_d2 got dout=%h v=%b e=%b rc=%h wc=%h exp all zero", d2_dout, d2_valid, d2_err, d2_rdc, d2_wrc);
        end
        checks++;
        if ({d3_dout, d3_valid, d3_err, d3_rdc, d3_wrc} !== 50'd0) begin
            errors++;
            $display("FAIL reset_d3 got dout=%h v=%b e=%b rc=%h wc=%h exp all zero", d3_dout, d3_valid, d3_err, d3_rdc, d3_wrc);
        end
        rst = 1'b0;
    endtask

    task automatic test_readback();
        step(1'b0, 1'b1, 16'd5, 16'hABCD);
        step(1'b1, 1'b0, 16'd5, 16'h0000);
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d2_valid !== 1'b0 || d3_valid !== 1'b0) begin
            errors++;
            $display("FAIL rb_early got v2=%b v3=%b exp 0 0", d2_valid, d3_valid);
        end
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d2_valid !== 1'b1 || d2_dout !== 16'hABCD) begin
            errors++;
            $display("FAIL rb_d2 got v=%b d=%h exp v=1 d=abcd", d2_valid, d2_dout);
        end
        checks++;
        if (d3_valid !== 1'b0) begin
            errors++;
            $display("FAIL rb_d3_early got v=%b exp 0", d3_valid);
        end
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d3_valid !== 1'b1 || d3_dout !== 16'hABCD) begin
            errors++;
            $display("FAIL rb_d3 got v=%b d=%h exp v=1 d=abcd", d3_valid, d3_dout);
        end
        checks++;
        if (d2_valid !== 1'b0 || d2_dout !== 16'hABCD) begin
            errors++;
            $display("FAIL rb_d2_hold got v=%b d=%h exp v=0 d=abcd", d2_valid, d2_dout);
        end
        checks++;
        if ({d2_wrc, d2_rdc, d2_err} !== {16'd1, 16'd1, 1'b0} || {d3_wrc, d3_rdc, d3_err} !== {16'd1, 16'd1, 1'b0}) begin
            errors++;
            $display("FAIL rb_counts got wc2=%h rc2=%h e2=%b wc3=%h rc3=%h e3=%b exp 1 1 0", d2_wrc, d2_rdc, d2_err, d3_wrc, d3_rdc, d3_err);
        end
    endtask

    task automatic test_burst();
        logic [15:0] e;
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            e = 16'h1000 + i[15:0];
            step(1'b0, 1'b1, i[15:0], e);
        end
        for (int j = 0; j < 19; j++) begin
            step(j < 16, 1'b0, (j < 16) ? j[15:0] : 16'd0, 16'h0000);
            checks++;
            if (d2_valid !== (j >= 2 && j < 18)) begin
                errors++;
                $display("FAIL burst_d2_valid cyc %0d got %b exp %b", j, d2_valid, (j >= 2 && j < 18));
            end
            if (j >= 2 && j < 18) begin
                e = 16'h1000 + j[15:0] - 16'd2;
                checks++;
                if (d2_dout !== e) begin
                    errors++;
                    $display("FAIL burst_d2_data cyc %0d got %h exp %h", j, d2_dout, e);
                end
            end
            checks++;
            if (d3_valid !== (j >= 3)) begin
                errors++;
                $display("FAIL burst_d3_valid cyc %0d got %b exp %b", j, d3_valid, (j >= 3));
            end
            if (j >= 3) begin
                e = 16'h1000 + j[15:0] - 16'd3;
                checks++;
                if (d3_dout !== e) begin
                    errors++;
                    $display("FAIL burst_d3_data cyc %0d got %h exp %h", j, d3_dout, e);
                end
            end
        end
        checks++;
        if (d2_rdc !== 16'd16 || d3_rdc !== 16'd16 || d2_wrc !== 16'd16 || d3_wrc !== 16'd16) begin
            errors++;
            $display("FAIL burst_counts got rc2=%h rc3=%h wc2=%h wc3=%h exp 0010", d2_rdc, d3_rdc, d2_wrc, d3_wrc);
        end
    endtask

    task automatic test_out_of_range();
        step(1'b0, 1'b1, 16'h03FF, 16'hBEEF);
        pulse_reset();
        step(1'b1, 1'b0, 16'h03FF, 16'h0000);
        checks++;
        if (d2_err !== 1'b0 || d3_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_top_word_err got e2=%b e3=%b exp 0 0", d2_err, d3_err);
        end
        step(1'b1, 1'b0, 16'h0400, 16'h0000);
        checks++;
        if (d2_err !== 1'b1 || d3_err !== 1'b1 || d2_rdc !== 16'd2 || d3_rdc !== 16'd2) begin
            errors++;
            $display("FAIL oor_err got e2=%b e3=%b rc2=%h rc3=%h exp 1 1 0002 0002", d2_err, d3_err, d2_rdc, d3_rdc);
        end
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d2_valid !== 1'b1 || d2_dout !== 16'hBEEF) begin
            errors++;
            $display("FAIL oor_d2_top got v=%b d=%h exp v=1 d=beef", d2_valid, d2_dout);
        end
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d2_valid !== 1'b1 || d2_dout !== 16'h0000) begin
            errors++;
            $display("FAIL oor_d2_zero got v=%b d=%h exp v=1 d=0000", d2_valid, d2_dout);
        end
        checks++;
        if (d3_valid !== 1'b1 || d3_dout !== 16'hBEEF) begin
            errors++;
            $display("FAIL oor_d3_top got v=%b d=%h exp v=1 d=beef", d3_valid, d3_dout);
        end
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d3_valid !== 1'b1 || d3_dout !== 16'h0000) begin
            errors++;
            $display("FAIL oor_d3_zero got v=%b d=%h exp v=1 d=0000", d3_valid, d3_dout);
        end
        step(1'b0, 1'b1, 16'hFFFF, 16'h9999);
        checks++;
        if (d2_wrc !== 16'd0 || d3_wrc !== 16'd0) begin
            errors++;
            $display("FAIL oor_write_count got wc2=%h wc3=%h exp 0000", d2_wrc, d3_wrc);
        end
        repeat (10) step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d2_err !== 1'b1 || d3_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_sticky got e2=%b e3=%b exp 1 1", d2_err, d3_err);
        end
    endtask

    task automatic test_conflict();
        pulse_reset();
        step(1'b0, 1'b1, 16'd3, 16'h1234);
        step(1'b1, 1'b1, 16'd3, 16'h5555);
        checks++;
        if (d2_err !== 1'b1 || d3_err !== 1'b1 || d2_wrc !== 16'd1 || d3_wrc !== 16'd1 || d2_rdc !== 16'd0 || d3_rdc !== 16'd0) begin
            errors++;
            $display("FAIL conf_state got e2=%b e3=%b wc2=%h wc3=%h rc2=%h rc3=%h exp 1 1 1 1 0 0", d2_err, d3_err, d2_wrc, d3_wrc, d2_rdc, d3_rdc);
        end
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b0, 16'd0, 16'h0000);
            checks++;
            if (d2_valid !== 1'b0 || d3_valid !== 1'b0) begin
                errors++;
                $display("FAIL conf_no_valid cyc %0d got v2=%b v3=%b exp 0 0", j, d2_valid, d3_valid);
            end
        end
        step(1'b1, 1'b0, 16'd3, 16'h0000);
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d2_valid !== 1'b1 || d2_dout !== 16'h1234) begin
            errors++;
            $display("FAIL conf_reread_d2 got v=%b d=%h exp v=1 d=1234", d2_valid, d2_dout);
        end
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d3_valid !== 1'b1 || d3_dout !== 16'h1234) begin
            errors++;
            $display("FAIL conf_reread_d3 got v=%b d=%h exp v=1 d=1234", d3_valid, d3_dout);
        end
    endtask

    task automatic test_snapshot();
        step(1'b0, 1'b1, 16'd7, 16'h1111);
        step(1'b1, 1'b0, 16'd7, 16'h0000);
        step(1'b0, 1'b1, 16'd7, 16'h2222);
        step(1'b1, 1'b0, 16'd7, 16'h0000);
        checks++;
        if (d2_valid !== 1'b1 || d2_dout !== 16'h1111) begin
            errors++;
            $display("FAIL snap_d2_old got v=%b d=%h exp v=1 d=1111", d2_valid, d2_dout);
        end
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d3_valid !== 1'b1 || d3_dout !== 16'h1111 || d2_valid !== 1'b0) begin
            errors++;
            $display("FAIL snap_d3_old got v3=%b d3=%h v2=%b exp 1 1111 0", d3_valid, d3_dout, d2_valid);
        end
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d2_valid !== 1'b1 || d2_dout !== 16'h2222 || d3_valid !== 1'b0) begin
            errors++;
            $display("FAIL snap_d2_new got v2=%b d2=%h v3=%b exp 1 2222 0", d2_valid, d2_dout, d3_valid);
        end
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d3_valid !== 1'b1 || d3_dout !== 16'h2222) begin
            errors++;
            $display("FAIL snap_d3_new got v=%b d=%h exp v=1 d=2222", d3_valid, d3_dout);
        end
    endtask

    task automatic test_reset_mid_burst();
        step(1'b1, 1'b0, 16'd7, 16'h0000);
        step(1'b1, 1'b0, 16'd5, 16'h0000);
        rd = 1'b0; wr = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({d2_dout, d2_valid, d2_err, d2_rdc, d2_wrc} !== 50'd0 || {d3_dout, d3_valid, d3_err, d3_rdc, d3_wrc} !== 50'd0) begin
            errors++;
            $display("FAIL midrst_async got d2=%h v2=%b rc2=%h d3=%h v3=%b rc3=%h exp all zero", d2_dout, d2_valid, d2_rdc, d3_dout, d3_valid, d3_rdc);
        end
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (d2_valid !== 1'b0 || d3_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_discard cyc %0d got v2=%b v3=%b exp 0 0", j, d2_valid, d3_valid);
            end
            step(1'b0, 1'b0, 16'd0, 16'h0000);
        end
        step(1'b1, 1'b0, 16'd7, 16'h0000);
        step(1'b1, 1'b0, 16'd5, 16'h0000);
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d2_valid !== 1'b1 || d2_dout !== 16'h2222) begin
            errors++;
            $display("FAIL midrst_d2_w7 got v=%b d=%h exp v=1 d=2222", d2_valid, d2_dout);
        end
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d2_valid !== 1'b1 || d2_dout !== 16'h1005 || d3_valid !== 1'b1 || d3_dout !== 16'h2222) begin
            errors++;
            $display("FAIL midrst_mix got v2=%b d2=%h v3=%b d3=%h exp 1 1005 1 2222", d2_valid, d2_dout, d3_valid, d3_dout);
        end
        step(1'b0, 1'b0, 16'd0, 16'h0000);
        checks++;
        if (d3_valid !== 1'b1 || d3_dout !== 16'h1005) begin
            errors++;
            $display("FAIL midrst_d3_w5 got v=%b d=%h exp v=1 d=1005", d3_valid, d3_dout);
        end
    endtask

    initial begin
        rst  = 1'b1;
        rd   = 1'b0;
        wr   = 1'b0;
        addr = 16'h0000;
        din  = 16'h0000;
        test_reset();
        test_readback();
        test_burst();
        test_out_of_range();
        test_conflict();
        test_snapshot();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_mem_responder.md
# sys_mem_responder

System-memory responder for the vector processor's memory bus. It serves the processor's `Addr`/`RD`/`WR` requests from an internal word-addressed array and returns read data after a fixed, parameterised pipeline latency. Back-to-back reads are supported, so a vector load can hold `RD` high and sweep `Addr` one word per cycle. It sits between the processor core and the bench or top level, and flags protocol and address errors.

## Interface
Parameters:
- `ADDR_W`, 10: array depth is 2^ADDR_W 16-bit words.
- `RD_LAT`, 1: read latency in cycles; legal range 1..4.
- `BASE`, 16'h0000: bus address of array word 0.

Ports:
- `Clk`  in  1  single clock; all state is updated on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Addr`  in  16  bus word address, driven by the processor.
- `RD`  in  1  read request, sampled on each rising edge.
- `WR`  in  1  write request, sampled on each rising edge.
- `DataIn`  in  16  write data; this is the processor's `DataOut`.
- `DataOut`  out  16  read data; this is the processor's `DataIn`.
- `Valid`  out  1  `DataOut` carries a completed read this cycle.
- `Err`  out  1  sticky error flag.
- `RdCount`  out  16  number of reads performed, saturating.
- `WrCount`  out  16  number of writes performed, saturating.

## Operation
- Offset is `off = Addr - BASE`, computed modulo 2^16. The address is in range when `off < 2^ADDR_W`.
- Each rising edge classifies the request from `RD`/`WR`:
  - IDLE (`RD`=0, `WR`=0): no action.
  - READ (`RD`=1, `WR`=0): the data word is captured from the array at this edge and pushed into stage 1 of the read pipeline.
    - An out-of-range read captures 16'h0000 and sets `Err`.
    - Every read increments `RdCount`, in range or not.
  - WRITE (`RD`=0, `WR`=1): `DataIn` is written to `array[off]` at this edge and `WrCount` increments.
    - An out-of-range write is dropped, sets `Err`, and does not increment `WrCount`.
  - CONFLICT (`RD`=1, `WR`=1): no read and no write. `Err` is set, no pipeline entry is made, and counters are unchanged.
- Read pipeline:
  - It has `RD_LAT` stages, each holding a valid bit and 16-bit data. Entries advance one stage per edge.
  - When an entry leaves the last stage, `DataOut` takes its data and `Valid` is 1.
  - Otherwise `Valid` is 0 and `DataOut` holds its last value.
- Read data is a snapshot taken at the issue edge. A write to the same word while the read is in flight does not change the returned data.
- Read-after-write: a read issued one or more edges after a write to the same word returns the new data.
- `Err` is cleared only by `Reset`. It is set by an out-of-range access, by a CONFLICT, or by `RD`/`WR` being X.
- Counters saturate at 16'hFFFF.
- Array contents are not reset. An uninitialised word reads as X.
- `Reset` asserted at any time (async):
  - `DataOut`=16'h0000, `Valid`=0, `Err`=0, `RdCount`=0, `WrCount`=0.
  - All pipeline valid bits are cleared, so in-flight reads are discarded and never produce `Valid`.
  - Array contents are retained.
- `RD_LAT` outside 1..4 is an elaboration error.

## Timing
- Read issued at edge k: `DataOut`/`Valid` change at edge k+`RD_LAT` and stay valid for one cycle.
- With `RD_LAT`=1, data is visible in the cycle after the issue edge.
- Throughput is one read or one write per cycle, with no bubbles.
  - N consecutive READ edges produce N consecutive `Valid` cycles, in issue order.
- A write takes effect at its edge. Write-to-read turnaround has no penalty.
- Mixed traffic (a read, then a write, then a read) keeps strict request order. There is no reordering.
- `Err` and the counters update at the same edge that classifies the request.
- Reset deassertion: the first request is sampled at the first rising edge after `Reset` falls.

## Test plan
- Basic read-back, `RD_LAT`=2: after reset, write 16'hABCD to `Addr`=5, then read `Addr`=5 on the next edge.
  - Required: `Valid`=1 and `DataOut`=16'hABCD two edges after the read issue; `WrCount`=1, `RdCount`=1, `Err`=0.
- Burst: write 16'h1000+i to words 0..15, then hold `RD`=1 for 16 edges with `Addr`=0..15.
  - Required: 16 consecutive `Valid` cycles with data 16'h1000..16'h100F in order; `RdCount`=16.
- Out of range, `ADDR_W`=10, `BASE`=0: read `Addr`=16'h0400.
  - Required: `Valid`=1 with `DataOut`=16'h0000, and `Err`=1.
  - `Err` must still be 1 after 10 further idle cycles.
- Conflict: word 3 holds 16'h1234; drive `RD`=`WR`=1 at `Addr`=3 with `DataIn`=16'h5555.
  - Required: `Err`=1, no `Valid`, counters unchanged; a later read of word 3 returns 16'h1234.
- Snapshot, `RD_LAT`=3: word 7 holds 16'h1111; read word 7, then write 16'h2222 to word 7 on the next edge.
  - Required: the first read returns 16'h1111; a following read returns 16'h2222.
- Reset mid-burst, `RD_LAT`=3: assert `Reset` between edges while two reads are in flight.
  - Required: outputs drop to zero immediately; no `Valid` ever appears for those reads; array data is intact on re-read.
